// File: rtl/axis_gpio_ascii_ctrl.sv
// Byte-wide AXI4-Stream sniffer: captures GPIO_WIDTH ASCII '0'/'1' chars at BYTE_START and commits them to gpio_out per good frame.
// Optional rejected-frame counter on err_count when AXIS_GPIO_ERR_CNT_EN is defined.
module axis_gpio_ascii_ctrl #(
    parameter int BYTE_START = 42,
    parameter int GPIO_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  gpio_update,
    output logic                  frame_err,
`ifdef AXIS_GPIO_ERR_CNT_EN
    output logic [15:0]           err_count,
`endif
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        ST_SKIP    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_COMMIT  = 2'd3
    } state_t;

    localparam int              CW            = (GPIO_WIDTH > 1) ? $clog2(GPIO_WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_CHAR     = CW'(GPIO_WIDTH - 1);
    localparam logic [15:0]     SKIP_LAST     = 16'(BYTE_START - 1);
    localparam bit              START_AT_ZERO = (BYTE_START == 0);

    state_t                  state_q, state_d;
    logic [15:0]             pos_q, pos_d;
    logic [GPIO_WIDTH-1:0]   shadow_q, shadow_d;
    logic                    bad_q, bad_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    short_q, short_d;
    logic                    tready_q, tready_d;
    logic [GPIO_WIDTH-1:0]   gpio_q, gpio_d;
    logic                    upd_q, upd_d;
    logic                    ferr_q, ferr_d;
`ifdef AXIS_GPIO_ERR_CNT_EN
    logic [15:0]             errcnt_q, errcnt_d;
`endif

    // Handshake: a byte moves only on a cycle where s_axis_tvalid and s_axis_tready are both high;
    // tready is a register of the next state, never a function of tvalid.
    logic accept;
    logic char_bit;
    logic char_bad;
    logic capturing;

    always_comb begin
        accept    = s_axis_tvalid & tready_q;
        char_bit  = (s_axis_tdata == 8'h31);
        char_bad  = (s_axis_tdata != 8'h30) && (s_axis_tdata != 8'h31);
        capturing = (state_q == ST_CAPTURE) || ((state_q == ST_SKIP) && START_AT_ZERO);

        state_d  = state_q;
        pos_d    = pos_q;
        shadow_d = shadow_q;
        bad_d    = bad_q;
        cnt_d    = cnt_q;
        gpio_d   = gpio_q;
        upd_d    = 1'b0;
        short_d  = 1'b0;
        // A short frame seen last cycle reports its error now, matching the commit latency.
        ferr_d   = short_q;

        if (accept) begin
            if (s_axis_tlast) begin
                pos_d = 16'd0;
            end else if (pos_q != 16'hFFFF) begin
                pos_d = pos_q + 16'd1;
            end
        end

        case (state_q)
            ST_SKIP, ST_CAPTURE: begin
                if (accept) begin
                    if (capturing) begin
                        shadow_d = (shadow_q << 1) | GPIO_WIDTH'(char_bit);
                        bad_d    = bad_q | char_bad;
                        cnt_d    = cnt_q + 1'b1;
                        if (cnt_q == LAST_CHAR) begin
                            cnt_d   = '0;
                            state_d = s_axis_tlast ? ST_COMMIT : ST_DRAIN;
                        end else if (s_axis_tlast) begin
                            cnt_d   = '0;
                            bad_d   = 1'b0;
                            short_d = 1'b1;
                            state_d = ST_SKIP;
                        end else begin
                            state_d = ST_CAPTURE;
                        end
                    end else if (s_axis_tlast) begin
                        short_d = 1'b1;
                    end else if (pos_q == SKIP_LAST) begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_DRAIN: begin
                if (accept && s_axis_tlast) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (!bad_q) begin
                    gpio_d = shadow_q;
                    upd_d  = 1'b1;
                end else begin
                    ferr_d = 1'b1;
                end
                bad_d   = 1'b0;
                state_d = ST_SKIP;
            end
            default: begin
                state_d = ST_SKIP;
            end
        endcase

        tready_d = (state_d != ST_COMMIT);
    end

`ifdef AXIS_GPIO_ERR_CNT_EN
    always_comb begin
        errcnt_d = errcnt_q;
        if (ferr_d && (errcnt_q != 16'hFFFF)) begin
            errcnt_d = errcnt_q + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_SKIP;
            pos_q    <= 16'd0;
            shadow_q <= '0;
            bad_q    <= 1'b0;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            tready_q <= 1'b0;
            gpio_q   <= '0;
            upd_q    <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef AXIS_GPIO_ERR_CNT_EN
            errcnt_q <= 16'd0;
`endif
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            shadow_q <= shadow_d;
            bad_q    <= bad_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            tready_q <= tready_d;
            gpio_q   <= gpio_d;
            upd_q    <= upd_d;
            ferr_q   <= ferr_d;
`ifdef AXIS_GPIO_ERR_CNT_EN
            errcnt_q <= errcnt_d;
`endif
        end
    end

    assign s_axis_tready = tready_q;
    assign gpio_out      = gpio_q;
    assign gpio_update   = upd_q;
    assign frame_err     = ferr_q;
    assign dbg_state_o   = state_q;
`ifdef AXIS_GPIO_ERR_CNT_EN
    assign err_count     = errcnt_q;
`endif

endmodule

// File: doc/axis_gpio_ascii_ctrl.md
# axis_gpio_ascii_ctrl

Parametrised AXI4-Stream frame sniffer that drives GPIO outputs from an ASCII bit string carried in received Ethernet/UDP payloads. It sits on the byte-wide receive stream after the MAC/UDP path, as the successor to the fixed 2-bit LED decoder. It extracts GPIO_WIDTH characters ('0'/'1') starting at a configurable byte offset, validates them, and applies them atomically only when the whole frame is good. It observes proper valid/ready handshakes and inserts one back-pressure cycle per frame to commit.

## Interface
- BYTE_START, 42: byte index (0-based) of the first ASCII character within the frame; legal 0..65534-GPIO_WIDTH.
- GPIO_WIDTH, 4: number of characters captured and GPIO bits driven; 1..32.
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  reset; synchronous, active-low.
- s_axis_tdata  in  8  frame byte.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tlast  in  1  last byte of frame.
- s_axis_tready  out  1  byte accepted when tvalid & tready.
- gpio_out  out  GPIO_WIDTH  applied GPIO state; first captured char maps to MSB.
- gpio_update  out  1  one-cycle pulse when gpio_out is loaded.
- frame_err  out  1  one-cycle pulse when a frame is rejected.
- err_count  out  16  rejected-frame counter (only with AXIS_GPIO_ERR_CNT_EN).

## Operation
- Only accepted beats (tvalid & tready) advance any state. tvalid low stalls everything.
- 16-bit byte counter `pos`: clears on accepted tlast; otherwise increments per accepted beat, saturating at 0xFFFF.
- FSM states and transitions:
  - SKIP: accept bytes until pos == BYTE_START-1 is accepted, then go to CAPTURE. With BYTE_START==0, SKIP exits directly into CAPTURE at frame start. Accepted tlast in SKIP is a short frame: pulse frame_err in the next cycle, pos=0, stay in SKIP. This path does not enter COMMIT.
  - CAPTURE: on each accepted byte, shift the bit into the shadow register: 0x30 gives 0, 0x31 gives 1. Any other value sets the `bad` flag and shifts in 0. After the GPIO_WIDTH-th character, go to COMMIT if tlast came with it, otherwise go to DRAIN. A tlast before the last character is a short frame: frame_err, clear `bad`, return to SKIP.
  - DRAIN: accept bytes, ignoring data, until tlast, then go to COMMIT.
  - COMMIT: s_axis_tready=0 for exactly one cycle. If `bad` is clear, gpio_out <= shadow and gpio_update pulses. If `bad` is set, gpio_out is held and frame_err pulses. Clear `bad` and go to SKIP.
- gpio_out never changes except in COMMIT with a good frame. Partial or bad frames leave it untouched.
- Reset (at any time, including mid-frame): state=SKIP, pos=0, shadow=0, bad=0. The next accepted beat is treated as byte 0 of a new frame.

## Timing
- Reset values: s_axis_tready=0 while reset_n=0, and 1 from the first cycle after release (SKIP). gpio_out=0, gpio_update=0, frame_err=0, err_count=0.
- s_axis_tready is registered-state derived: it is 1 in SKIP, CAPTURE and DRAIN, and 0 in COMMIT only. It does not depend combinationally on tvalid.
- Latency: tlast is accepted at edge N. gpio_out/gpio_update (or frame_err) are registered at edge N+1 and valid during cycle N+1 to N+2. Pulses last exactly one cycle.
- Short-frame frame_err is also registered at the edge after the tlast beat. No ready drop occurs for short frames.
- Back-to-back frames: the first byte of the next frame is accepted no earlier than edge N+2.
- Frames of 65536 bytes or more: pos saturates and no recapture occurs. Behaviour is otherwise unchanged.

## Configuration
- AXIS_GPIO_ERR_CNT_EN defined: err_count port and a 16-bit counter exist. The counter increments on every frame_err pulse and saturates at 0xFFFF without wrapping. Reset clears it to 0.
- Not defined: the err_count port and counter are absent, and frame_err still pulses. All other behaviour is identical.

## Test plan
- Defaults: 60-byte frame with "1010" at bytes 42..45, tvalid continuous → gpio_out=4'b1010 and gpio_update pulses 1 cycle after tlast. tready is low for exactly that cycle.
- The same frame with tvalid deasserted randomly for 1–3 cycles inside bytes 40..47 → identical result (gpio_out=4'hA). No extra or missing captures.
- Frame with "10x1" at bytes 42..45 (0x78) → frame_err pulses and gpio_out keeps its prior 4'hA. err_count goes from 0 to 1 when the macro is defined.
- 44-byte frame (tlast on byte 43) → frame_err 1 cycle after tlast, no ready drop, gpio_out unchanged. The following good "0111" frame gives gpio_out=4'b0111.
- Reset asserted for 1 cycle at byte 43 of a "1111" frame, then a fresh good "0001" frame → gpio_out=0 after reset, then 4'b0001. The remainder of the interrupted frame is parsed as a new frame, and ends as a short-frame error.
- BYTE_START=0, GPIO_WIDTH=1: single-byte frame 0x31 with tlast → gpio_out=1'b1. Back-to-back frames: the next frame's byte 0 is not accepted before tready returns high.
